// File: rtl/exe_stage_if.sv
// Bundle of the exe stage's pipeline handshake, decode/memory buses and data SRAM request.
// "slave" is the execute stage's own view; "master" is the surrounding pipeline.
interface exe_stage_if #(
    parameter int DS_TO_ES_BUS_WD = 145,
    parameter int ES_TO_MS_BUS_WD = 71
);
    logic                       ms_allowin;
    logic                       es_allowin;
    logic                       ds_to_es_valid;
    logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus;
    logic                       es_to_ms_valid;
    logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
    logic [39:0]                back_to_id_stage_bus_from_exe;
    logic                       data_sram_en;
    logic [3:0]                 data_sram_wen;
    logic [31:0]                data_sram_addr;
    logic [31:0]                data_sram_wdata;

    modport slave (
        input  ms_allowin, ds_to_es_valid, ds_to_es_bus,
        output es_allowin, es_to_ms_valid, es_to_ms_bus, back_to_id_stage_bus_from_exe,
        output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
    );

    modport master (
        output ms_allowin, ds_to_es_valid, ds_to_es_bus,
        input  es_allowin, es_to_ms_valid, es_to_ms_bus, back_to_id_stage_bus_from_exe,
        input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
    );
endinterface

// File: rtl/exe_stage.sv
// MIPS execute stage: ALU, HI/LO, combinational multiplier, 32-step restoring divider.
// state | meaning:  IDLE | no divide in progress;  BUSY | one quotient bit per cycle;  DONE | result ready, waits for leave
module exe_stage #(
    parameter int DS_TO_ES_BUS_WD = 145,
    parameter int ES_TO_MS_BUS_WD = 71
) (
    input  logic        clk,
    input  logic        reset,
    exe_stage_if.slave  es_if
);
    typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_e;

    logic [DS_TO_ES_BUS_WD-1:0] ds_bus_q;
    logic                       es_valid_q;
    logic [31:0]                hi_q, hi_d, lo_q, lo_d;
    div_state_e                 state_q, state_d;
    logic [4:0]                 cnt_q, cnt_d;
    logic [31:0]                rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;

    logic [11:0] alu_op;
    logic        load_op, src1_is_sa, src1_is_pc, src2_imm_sext, src2_imm_zext, src2_is_8;
    logic        gr_we, mem_we, mult, multu, div, divu, mfhi, mflo, mthi, mtlo;
    logic [4:0]  dest;
    logic [15:0] imm;
    logic [31:0] rs_value, rt_value, pc;

    assign {alu_op, load_op, src1_is_sa, src1_is_pc, src2_imm_sext, src2_imm_zext, src2_is_8,
            gr_we, mem_we, mult, multu, div, divu, mfhi, mflo, mthi, mtlo,
            dest, imm, rs_value, rt_value, pc} = ds_bus_q;

    logic        is_div, es_ready_go, es_allowin, es_leave;
    logic [31:0] src1, src2, alu_res, es_result;
    logic [4:0]  sa;
    logic [63:0] mul_a, mul_b, prod;
    logic [32:0] trial, diff;
    logic [31:0] quo_fix, rem_fix;

    assign is_div      = div | divu;
    assign es_ready_go = !is_div || (state_q == DIV_DONE);
    assign es_allowin  = !es_valid_q || (es_ready_go && es_if.ms_allowin);
    assign es_leave    = es_valid_q && es_ready_go && es_if.ms_allowin;

    assign src1 = src1_is_sa    ? {27'b0, imm[10:6]} :
                  src1_is_pc    ? pc : rs_value;
    assign src2 = src2_imm_sext ? {{16{imm[15]}}, imm} :
                  src2_imm_zext ? {16'b0, imm} :
                  src2_is_8     ? 32'd8 : rt_value;
    assign sa   = src1[4:0];

    always_comb begin
        alu_res = ({32{alu_op[0]}}  & (src1 + src2))
                | ({32{alu_op[1]}}  & (src1 - src2))
                | ({32{alu_op[2]}}  & {31'b0, $signed(src1) < $signed(src2)})
                | ({32{alu_op[3]}}  & {31'b0, src1 < src2})
                | ({32{alu_op[4]}}  & (src1 & src2))
                | ({32{alu_op[5]}}  & ~(src1 | src2))
                | ({32{alu_op[6]}}  & (src1 | src2))
                | ({32{alu_op[7]}}  & (src1 ^ src2))
                | ({32{alu_op[8]}}  & (src2 << sa))
                | ({32{alu_op[9]}}  & (src2 >> sa))
                | ({32{alu_op[10]}} & 32'($signed(src2) >>> sa))
                | ({32{alu_op[11]}} & {src2[15:0], 16'b0});
    end

    assign es_result = mfhi ? hi_q : mflo ? lo_q : alu_res;

    // Extending to 64 bits first makes the truncated product correct for both signednesses.
    assign mul_a = mult ? {{32{rs_value[31]}}, rs_value} : {32'b0, rs_value};
    assign mul_b = mult ? {{32{rt_value[31]}}, rt_value} : {32'b0, rt_value};
    assign prod  = mul_a * mul_b;

    assign trial   = {rem_q, quo_q[31]};
    assign diff    = trial - {1'b0, dvs_q};
    assign quo_fix = (div && (rs_value[31] ^ rt_value[31])) ? -quo_q : quo_q;
    assign rem_fix = (div && rs_value[31]) ? -rem_q : rem_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        unique case (state_q)
            DIV_IDLE: begin
                if (es_valid_q && is_div) begin
                    state_d = DIV_BUSY;
                    cnt_d   = 5'd0;
                    rem_d   = 32'd0;
                    quo_d   = (div && rs_value[31]) ? -rs_value : rs_value;
                    dvs_d   = (div && rt_value[31]) ? -rt_value : rt_value;
                end
            end
            DIV_BUSY: begin
                // A clear borrow bit means the shifted remainder covered the divisor.
                if (!diff[32]) begin
                    rem_d = diff[31:0];
                    quo_d = {quo_q[30:0], 1'b1};
                end else begin
                    rem_d = trial[31:0];
                    quo_d = {quo_q[30:0], 1'b0};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = DIV_DONE;
            end
            DIV_DONE: begin
                if (es_leave) state_d = DIV_IDLE;
            end
            default: state_d = DIV_IDLE;
        endcase
    end

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (es_leave) begin
            if (mult || multu) begin
                hi_d = prod[63:32];
                lo_d = prod[31:0];
            end else if (is_div && (rt_value != 32'd0)) begin
                hi_d = rem_fix;
                lo_d = quo_fix;
            end
            if (mthi) hi_d = rs_value;
            if (mtlo) lo_d = rs_value;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            es_valid_q <= 1'b0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            state_q    <= DIV_IDLE;
            cnt_q      <= 5'd0;
        end else begin
            if (es_allowin) es_valid_q <= es_if.ds_to_es_valid;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (es_if.ds_to_es_valid && es_allowin) ds_bus_q <= es_if.ds_to_es_bus;
        rem_q <= rem_d;
        quo_q <= quo_d;
        dvs_q <= dvs_d;
    end

    assign es_if.es_allowin      = es_allowin;
    assign es_if.es_to_ms_valid  = es_valid_q && es_ready_go;
    assign es_if.es_to_ms_bus    = {load_op, gr_we, dest, es_result, pc};
    assign es_if.back_to_id_stage_bus_from_exe =
        {es_valid_q & load_op, es_result, es_valid_q, gr_we, dest};
    assign es_if.data_sram_en    = es_valid_q && (load_op || mem_we);
    assign es_if.data_sram_wen   = {4{es_valid_q & mem_we}};
    assign es_if.data_sram_addr  = alu_res;
    assign es_if.data_sram_wdata = rt_value;
endmodule

// File: tb/tb_exe_stage.sv
// Randomized self-checking bench for exe_stage against an arithmetic reference model.
module tb_exe_stage;
    typedef struct packed {
        logic [11:0] alu_op;
        logic        load_op, src1_is_sa, src1_is_pc, src2_imm_sext, src2_imm_zext, src2_is_8;
        logic        gr_we, mem_we, mult, multu, div, divu, mfhi, mflo, mthi, mtlo;
        logic [4:0]  dest;
        logic [15:0] imm;
        logic [31:0] rs, rt, pc;
    } ds_bus_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    exe_stage_if #(.DS_TO_ES_BUS_WD(145), .ES_TO_MS_BUS_WD(71)) bus_if ();
    exe_stage #(.DS_TO_ES_BUS_WD(145), .ES_TO_MS_BUS_WD(71)) dut (
        .clk   (clk),
        .reset (reset),
        .es_if (bus_if)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] m_hi, m_lo;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(ds_bus_t b);
        logic [31:0] s1, s2, r;
        int sh;
        s1 = b.src1_is_sa ? {27'b0, b.imm[10:6]} : (b.src1_is_pc ? b.pc : b.rs);
        if (b.src2_imm_sext)      s2 = {{16{b.imm[15]}}, b.imm};
        else if (b.src2_imm_zext) s2 = {16'b0, b.imm};
        else if (b.src2_is_8)     s2 = 32'd8;
        else                      s2 = b.rt;
        sh = int'(s1 % 32);
        case (b.alu_op)
            12'h001: r = s1 + s2;
            12'h002: r = s1 - s2;
            12'h004: r = (int'(s1) < int'(s2)) ? 32'd1 : 32'd0;
            12'h008: r = (s1 < s2) ? 32'd1 : 32'd0;
            12'h010: r = s1 & s2;
            12'h020: r = ~(s1 | s2);
            12'h040: r = s1 | s2;
            12'h080: r = s1 ^ s2;
            12'h100: r = s2 << sh;
            12'h200: r = s2 >> sh;
            12'h400: r = 32'(int'(s2) >>> sh);
            12'h800: r = s2 * 32'h10000;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] ref_result(ds_bus_t b);
        if (b.mfhi) return m_hi;
        if (b.mflo) return m_lo;
        return ref_alu(b);
    endfunction

    task automatic ref_retire(input ds_bus_t b);
        longint sp;
        logic [63:0] up;
        if (b.mult) begin
            sp = longint'(int'(b.rs)) * longint'(int'(b.rt));
            up = 64'(sp);
            m_hi = up[63:32];
            m_lo = up[31:0];
        end else if (b.multu) begin
            up = {32'b0, b.rs} * {32'b0, b.rt};
            m_hi = up[63:32];
            m_lo = up[31:0];
        end else if (b.div && b.rt != 0) begin
            m_lo = 32'(int'(b.rs) / int'(b.rt));
            m_hi = 32'(int'(b.rs) % int'(b.rt));
        end else if (b.divu && b.rt != 0) begin
            m_lo = b.rs / b.rt;
            m_hi = b.rs % b.rt;
        end
        if (b.mthi) m_hi = b.rs;
        if (b.mtlo) m_lo = b.rs;
    endtask

    // Issue one instruction with ms_allowin high and check it on the cycle it is offered downstream.
    task automatic send(input ds_bus_t b, input string tag);
        int wait_cyc;
        logic allow_seen;
        logic [31:0] exp_res;
        int exp_lat;
        exp_lat = (b.div || b.divu) ? 33 : 0;
        @(negedge clk);
        check({tag, "_allowin_idle"}, 32'(bus_if.es_allowin), 32'd1);
        bus_if.ds_to_es_bus   = b;
        bus_if.ds_to_es_valid = 1'b1;
        @(posedge clk);
        #1 bus_if.ds_to_es_valid = 1'b0;
        wait_cyc   = 0;
        allow_seen = 1'b0;
        @(negedge clk);
        while (!bus_if.es_to_ms_valid && wait_cyc < 100) begin
            if (bus_if.es_allowin) allow_seen = 1'b1;
            wait_cyc++;
            @(negedge clk);
        end
        check({tag, "_latency"}, 32'(wait_cyc), 32'(exp_lat));
        if (exp_lat > 0) check({tag, "_allowin_stall"}, 32'(allow_seen), 32'd0);
        exp_res = ref_result(b);
        check({tag, "_result"}, bus_if.es_to_ms_bus[63:32], exp_res);
        check({tag, "_es_result"}, bus_if.back_to_id_stage_bus_from_exe[38:7], exp_res);
        check({tag, "_ms_hdr"}, 32'(bus_if.es_to_ms_bus[70:64]), 32'({b.load_op, b.gr_we, b.dest}));
        check({tag, "_pc"}, bus_if.es_to_ms_bus[31:0], b.pc);
        check({tag, "_back_ld"}, 32'(bus_if.back_to_id_stage_bus_from_exe[39]), 32'(b.load_op));
        check({tag, "_sram_en"}, 32'(bus_if.data_sram_en), 32'(b.load_op | b.mem_we));
        check({tag, "_sram_wen"}, 32'(bus_if.data_sram_wen), b.mem_we ? 32'hF : 32'h0);
        if (b.load_op || b.mem_we) check({tag, "_sram_addr"}, bus_if.data_sram_addr, ref_alu(b));
        if (b.mem_we) check({tag, "_sram_wdata"}, bus_if.data_sram_wdata, b.rt);
        ref_retire(b);
        @(posedge clk);
    endtask

    function automatic ds_bus_t mk_mf(input logic hi);
        ds_bus_t b = '0;
        b.mfhi  = hi;
        b.mflo  = ~hi;
        b.gr_we = 1'b1;
        b.dest  = 5'd2;
        return b;
    endfunction

    function automatic ds_bus_t mk_div(input logic sgn, input logic [31:0] rs, input logic [31:0] rt);
        ds_bus_t b = '0;
        b.div  = sgn;
        b.divu = ~sgn;
        b.rs   = rs;
        b.rt   = rt;
        b.pc   = 32'hBFC0_0100;
        return b;
    endfunction

    initial begin
        ds_bus_t b;
        logic [11:0] one;
        int kind, op, sel;
        one = 12'd1;
        m_hi = 32'd0;
        m_lo = 32'd0;
        reset = 1'b1;
        bus_if.ms_allowin     = 1'b1;
        bus_if.ds_to_es_valid = 1'b0;
        bus_if.ds_to_es_bus   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_to_ms_valid", 32'(bus_if.es_to_ms_valid), 32'd0);
        check("rst_es_valid", 32'(bus_if.back_to_id_stage_bus_from_exe[6]), 32'd0);
        check("rst_allowin", 32'(bus_if.es_allowin), 32'd1);
        check("rst_sram_en", 32'(bus_if.data_sram_en), 32'd0);
        send(mk_mf(1'b1), "rst_hi");
        send(mk_mf(1'b0), "rst_lo");

        b = '0; b.alu_op = 12'h001; b.rs = 32'd5; b.rt = 32'd7; b.gr_we = 1'b1; b.dest = 5'd3;
        b.pc = 32'h0000_1000;
        send(b, "addu");

        b = '0; b.mult = 1'b1; b.rs = 32'hFFFF_FFFB; b.rt = 32'd3;
        send(b, "mult");
        send(mk_mf(1'b1), "mult_hi");
        send(mk_mf(1'b0), "mult_lo");
        check("mult_model_hi", m_hi, 32'hFFFF_FFFF);
        check("mult_model_lo", m_lo, 32'hFFFF_FFF1);

        send(mk_div(1'b1, 32'hFFFF_FFF9, 32'd2), "div");
        send(mk_mf(1'b1), "div_hi");
        send(mk_mf(1'b0), "div_lo");
        send(mk_div(1'b0, 32'hFFFF_FFFF, 32'h10), "divu");
        send(mk_mf(1'b1), "divu_hi");
        send(mk_mf(1'b0), "divu_lo");
        send(mk_div(1'b0, 32'h1234_5678, 32'd0), "divu0");
        send(mk_mf(1'b1), "divu0_hi");
        send(mk_mf(1'b0), "divu0_lo");

        // Store held by a stalled memory stage.
        b = '0; b.alu_op = 12'h001; b.src2_imm_sext = 1'b1; b.mem_we = 1'b1;
        b.rs = 32'h100; b.imm = 16'd4; b.rt = 32'hDEAD_BEEF;
        @(negedge clk);
        bus_if.ms_allowin     = 1'b0;
        bus_if.ds_to_es_bus   = b;
        bus_if.ds_to_es_valid = 1'b1;
        @(posedge clk);
        #1 bus_if.ds_to_es_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("sw_addr", bus_if.data_sram_addr, 32'h104);
            check("sw_wen", 32'(bus_if.data_sram_wen), 32'hF);
            check("sw_wdata", bus_if.data_sram_wdata, 32'hDEAD_BEEF);
            check("sw_allowin_low", 32'(bus_if.es_allowin), 32'd0);
        end
        bus_if.ms_allowin = 1'b1;
        #1;
        check("sw_allowin_rise", 32'(bus_if.es_allowin), 32'd1);
        check("sw_to_ms_valid", 32'(bus_if.es_to_ms_valid), 32'd1);
        @(posedge clk);

        b = '0; b.alu_op = 12'h001; b.src2_imm_sext = 1'b1; b.load_op = 1'b1; b.gr_we = 1'b1;
        b.rs = 32'h200; b.imm = 16'hFFF8; b.dest = 5'd9;
        send(b, "lw");

        // Reset in the middle of a divide.
        @(negedge clk);
        bus_if.ds_to_es_bus   = mk_div(1'b1, 32'd100, 32'd7);
        bus_if.ds_to_es_valid = 1'b1;
        @(posedge clk);
        #1 bus_if.ds_to_es_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(negedge clk);
        check("mid_rst_es_valid", 32'(bus_if.back_to_id_stage_bus_from_exe[6]), 32'd0);
        check("mid_rst_allowin", 32'(bus_if.es_allowin), 32'd1);
        send(mk_mf(1'b1), "mid_rst_hi");
        send(mk_mf(1'b0), "mid_rst_lo");
        send(mk_div(1'b1, 32'd100, 32'hFFFF_FFF9), "post_rst_div");
        send(mk_mf(1'b1), "post_rst_hi");
        send(mk_mf(1'b0), "post_rst_lo");

        for (int n = 0; n < 80; n++) begin
            b = '0;
            b.rs = $urandom; b.rt = $urandom; b.imm = 16'($urandom); b.pc = $urandom;
            b.dest = 5'($urandom); b.gr_we = 1'($urandom);
            kind = $urandom_range(0, 9);
            if (kind <= 3) begin
                op = $urandom_range(0, 12);
                b.alu_op = (op == 12) ? 12'd0 : (one << op);
                b.src1_is_sa = ($urandom_range(0, 3) == 0);
                b.src1_is_pc = ($urandom_range(0, 5) == 0);
                sel = $urandom_range(0, 3);
                b.src2_imm_sext = (sel == 0);
                b.src2_imm_zext = (sel == 1);
                b.src2_is_8     = (sel == 2);
            end else if (kind == 4) begin
                if ($urandom_range(0, 1) == 1) b.mult = 1'b1; else b.multu = 1'b1;
            end else if (kind == 5) begin
                if ($urandom_range(0, 1) == 1) b.mthi = 1'b1; else b.mtlo = 1'b1;
            end else if (kind <= 7) begin
                b = mk_mf(kind == 6);
            end else if (kind == 8) begin
                if ($urandom_range(0, 2) == 0) b.rt = $urandom_range(0, 20);
                if ($urandom_range(0, 1) == 1) b.div = 1'b1; else b.divu = 1'b1;
                if (b.div && b.rs == 32'h8000_0000 && b.rt == 32'hFFFF_FFFF) b.rt = 32'd3;
            end else begin
                b.alu_op = 12'h001;
                b.src2_imm_sext = 1'b1;
                if ($urandom_range(0, 1) == 1) b.load_op = 1'b1; else b.mem_we = 1'b1;
            end
            send(b, "rnd");
        end
        send(mk_mf(1'b1), "final_hi");
        send(mk_mf(1'b0), "final_lo");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline. It is the consumer end of the decode-to-execute bus and the producer of the execute-side forwarding/stall bus read by decode.
- Performs ALU operations and holds the HI/LO registers.
- Contains a combinational 32x32 multiplier and an iterative 32-step divider that stalls the stage.
- Issues data SRAM requests and forwards results to memory stage.

Parameters:
DS_TO_ES_BUS_WD, 145, decode-to-execute bus width
ES_TO_MS_BUS_WD, 71, execute-to-memory bus width

Ports:
clk  input  1  clock
reset  input  1  reset
ms_allowin  input  1  memory stage can accept
es_allowin  output  1  this stage can accept
ds_to_es_valid  input  1  decode output valid
ds_to_es_bus  input  145  fields: alu_op[144:133], load_op[132], src1_is_sa[131], src1_is_pc[130], src2_imm_sext[129], src2_imm_zext[128], src2_is_8[127], gr_we[126], mem_we[125], mult[124], multu[123], div[122], divu[121], mfhi[120], mflo[119], mthi[118], mtlo[117], dest[116:112], imm[111:96], rs_value[95:64], rt_value[63:32], pc[31:0]
es_to_ms_valid  output  1  result valid to memory stage
es_to_ms_bus  output  71  fields: res_from_mem[70], gr_we[69], dest[68:64], result[63:32], pc[31:0]
back_to_id_stage_bus_from_exe  output  40  fields: es_load_op[39], es_result[38:7], es_valid[6], es_gr_we[5], es_dest[4:0]
data_sram_en  output  1  SRAM access enable
data_sram_wen  output  4  byte write enables
data_sram_addr  output  32  address
data_sram_wdata  output  32  store data

Behaviour:
- Clock and reset: single clock clk. reset is synchronous, active-high.
- Reset state: es_valid=0, HI=LO=0, divider FSM=IDLE, iteration counter=0.
- Latched bus register is not reset; all outputs are qualified by es_valid.
- Handshake:
  - es_allowin = !es_valid | (es_ready_go & ms_allowin).
  - On each edge with es_allowin=1: es_valid <= ds_to_es_valid.
  - Bus is latched when ds_to_es_valid & es_allowin.
  - es_to_ms_valid = es_valid & es_ready_go.
  - "Leave" means es_valid & es_ready_go & ms_allowin at a clock edge.
- ALU operands:
  - src1 = src1_is_sa ? zero-extended imm[10:6] : src1_is_pc ? pc : rs_value.
  - src2 = src2_imm_sext ? sign-extended imm : src2_imm_zext ? zero-extended imm : src2_is_8 ? 32'd8 : rt_value.
- ALU operations (one-hot alu_op): 0 add, 1 sub (both wrap, no overflow trap), 2 signed slt, 3 unsigned sltu, 4 and, 5 nor, 6 or, 7 xor, 8 sll, 9 srl, 10 sra, 11 lui.
  - Shifts: amount is src1[4:0]; src2 is the shifted value.
  - lui: result = {src2[15:0], 16'b0}.
  - All-zero alu_op yields 0.
- Result select: mfhi → HI, mflo → LO, otherwise ALU result. The same value drives es_to_ms_bus.result and es_result.
- Multiply: mult is signed, multu unsigned, 64-bit product. On leave: HI <= product[63:32], LO <= product[31:0]. Stage does not stall.
- mthi / mtlo: on leave, HI (resp. LO) <= rs_value.
- Divider FSM, states IDLE, BUSY, DONE:
  - IDLE → BUSY when es_valid & (div|divu). Latch absolute values for div (raw values for divu); counter=0.
  - BUSY: one restoring step per cycle (shift the partial remainder left, compare/subtract, insert quotient bit). After the 32nd step → DONE.
  - DONE → IDLE on leave. Same edge applies sign fixups and writes HI/LO:
    - quotient is negated if operand signs differ (div only);
    - remainder takes the dividend's sign;
    - LO <= quotient, HI <= remainder.
  - Divisor 0: HI/LO are not written. Timing is unchanged.
- es_ready_go = !(div|divu) | (state==DONE).
  - Divide entering the stage at cycle N: BUSY during N+1..N+32, ready_go first high at N+33.
- Ordering: HI/LO writes occur on the leave edge, so the next instruction's mfhi/mflo sees the updated values.
- Data SRAM:
  - data_sram_en = es_valid & (load_op | mem_we).
  - data_sram_wen = {4{es_valid & mem_we}}.
  - data_sram_addr = ALU result; data_sram_wdata = rt_value.
  - Outputs are held while stalled; repeated writes are idempotent.
- Forwarding bus:
  - es_load_op = es_valid & load_op; es_valid = raw es_valid; es_gr_we = gr_we; es_dest = dest.
  - es_result always carries the current result, including a partial value while the stage is stalled.
- res_from_mem on es_to_ms_bus = load_op.
- Reset mid-division forces IDLE and es_valid=0. The in-flight instruction is discarded and HI/LO clear to 0.

Test Plan:
- addu: rs_value=5, rt_value=7, alu_op=bit0 → result 12, es_to_ms_valid high in the cycle after acceptance, es_allowin=1.
- mult rs=0xFFFFFFFB (-5), rt=3, then mfhi, then mflo → HI=0xFFFFFFFF, LO=0xFFFFFFF1, mfhi result 0xFFFFFFFF, mflo result 0xFFFFFFF1.
- div rs=-7, rt=2 → es_ready_go low for exactly 32 cycles after entry, es_allowin low meanwhile; on leave LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu 0xFFFFFFFF / 0x10 → LO=0x0FFFFFFF, HI=0xF. Also divu by 0 → HI/LO unchanged, 33-cycle latency.
- sw with rs=0x100, imm=4, rt=0xDEADBEEF, ms_allowin held low 3 cycles → addr 0x104, wen=4'hF, wdata=0xDEADBEEF stable, es_allowin=0 until ms_allowin rises. lw → back bus bit39=1.
- Assert reset during BUSY (cycle 10 of a div) → next cycle es_valid=0, FSM IDLE, HI=LO=0. A subsequent div completes normally.
